// File: rtl/rf_spi_master_pkg.sv
// Shared types and constants for the RF transceiver SPI master.
package rf_spi_master_pkg;

  typedef enum logic [1:0] {
    INST_SHORT_RD = 2'b00,
    INST_SHORT_WR = 2'b01,
    INST_LONG_RD  = 2'b10,
    INST_LONG_WR  = 2'b11
  } inst_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_e;

  localparam int         SHORT_FRAME_BITS = 16;
  localparam int         LONG_FRAME_BITS  = 24;
  localparam logic [3:0] LONG_PAD         = 4'b0000;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Frame left-aligned in 24 bits so the MSB is always bit 23.
  function automatic logic [23:0] build_frame(input inst_e inst, input logic [9:0] addr,
                                              input logic [7:0] data);
    logic [7:0] dphase;
    dphase = inst[0] ? data : 8'h00;
    if (inst[1]) build_frame = {1'b1, addr, inst[0], LONG_PAD, dphase};
    else         build_frame = {1'b0, addr[5:0], inst[0], dphase, 8'h00};
  endfunction

endpackage

// File: rtl/rf_spi_master_if.sv
// Command/response bus between the RF control FSM and the SPI master.
interface rf_spi_master_if;
  import rf_spi_master_pkg::*;

  inst_e      inst;
  logic [9:0] addr_in;
  logic [7:0] data_in;
  logic       cs_in;
  logic       ready;
  logic [7:0] rd_data;
  logic       rd_valid;

  modport master (output inst, addr_in, data_in, cs_in, input ready, rd_data, rd_valid);
  modport slave  (input inst, addr_in, data_in, cs_in, output ready, rd_data, rd_valid);
endinterface

// File: rtl/rf_spi_master_sync2.sv
// Two-flop synchroniser for asynchronous pins, with selectable reset value.
module rf_spi_master_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/rf_spi_master.sv
// SPI master: one {inst, addr, data} command becomes one mode-0 frame to the transceiver.
// states: IDLE wait cmd | SETUP cs_n low | SHIFT bits | HOLD sclk idle | GAP cs_n high
module rf_spi_master
  import rf_spi_master_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic clk,
  input  logic rst,
  rf_spi_master_if.slave bus,
  output logic sclk,
  output logic mosi,
  input  logic miso,
  output logic cs_n,
  input  logic intr_n,
  output logic intr
);
  localparam int MAXP = max2(max2(CLK_DIV, CS_SETUP), max2(CS_HOLD, CS_GAP));
  localparam int CW   = $clog2(MAXP) + 1;

  state_e        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [4:0]    bit_cnt, bit_n;
  logic [23:0]   shreg, shreg_n, frame;
  logic          wr_q, wr_n;
  logic          sclk_n, mosi_n, cs_n_n;
  logic [7:0]    rd_data_q, rd_data_n, rx;
  logic          rd_valid_q, rd_valid_n;
  logic          rise, rx_clr;
  logic [1:0]    rise_p;
  logic          miso_s, intr_s;

  rf_spi_master_sync2 #(.RST_VAL(1'b0)) u_sync_miso (.clk(clk), .rst(rst), .d(miso),   .q(miso_s));
  rf_spi_master_sync2 #(.RST_VAL(1'b1)) u_sync_intr (.clk(clk), .rst(rst), .d(intr_n), .q(intr_s));

  assign intr         = ~intr_s;
  assign bus.ready    = (state == ST_IDLE);
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_n      = bit_cnt;
    shreg_n    = shreg;
    wr_n       = wr_q;
    sclk_n     = sclk;
    mosi_n     = mosi;
    cs_n_n     = cs_n;
    rd_data_n  = rd_data_q;
    rd_valid_n = 1'b0;
    rise       = 1'b0;
    rx_clr     = 1'b0;
    frame      = '0;
    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        bit_n = '0;
        if (bus.cs_in) begin
          frame   = build_frame(bus.inst, bus.addr_in, bus.data_in);
          shreg_n = frame;
          mosi_n  = frame[23];
          cs_n_n  = 1'b0;
          wr_n    = bus.inst[0];
          bit_n   = bus.inst[1] ? 5'(LONG_FRAME_BITS - 1) : 5'(SHORT_FRAME_BITS - 1);
          cnt_n   = CW'(CS_SETUP - 1);
          rx_clr  = 1'b1;
          state_n = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt == '0) begin
          cnt_n   = CW'(CLK_DIV - 1);
          state_n = ST_SHIFT;
        end else cnt_n = cnt - 1'b1;
      end
      ST_SHIFT: begin
        if (cnt != '0) cnt_n = cnt - 1'b1;
        else begin
          cnt_n = CW'(CLK_DIV - 1);
          if (!sclk) begin
            sclk_n = 1'b1;
            rise   = 1'b1;
          end else begin
            sclk_n = 1'b0;
            if (bit_cnt == '0) begin
              mosi_n  = 1'b0;
              cnt_n   = CW'(CS_HOLD - 1);
              state_n = ST_HOLD;
            end else begin
              bit_n   = bit_cnt - 5'd1;
              shreg_n = {shreg[22:0], 1'b0};
              mosi_n  = shreg[22];
            end
          end
        end
      end
      ST_HOLD: begin
        if (cnt == '0) begin
          cs_n_n  = 1'b1;
          cnt_n   = CW'(CS_GAP - 1);
          state_n = ST_GAP;
        end else cnt_n = cnt - 1'b1;
      end
      ST_GAP: begin
        if (cnt == '0) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
          if (!wr_q) begin
            rd_data_n  = rx;
            rd_valid_n = 1'b1;
          end
        end else cnt_n = cnt - 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // The sample strobe trails the sclk rise by the synchroniser depth, so rx
  // captures the miso level that was present at the rising edge itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      wr_q       <= 1'b0;
      sclk       <= 1'b0;
      mosi       <= 1'b0;
      cs_n       <= 1'b1;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rx         <= '0;
      rise_p     <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_cnt    <= bit_n;
      shreg      <= shreg_n;
      wr_q       <= wr_n;
      sclk       <= sclk_n;
      mosi       <= mosi_n;
      cs_n       <= cs_n_n;
      rd_data_q  <= rd_data_n;
      rd_valid_q <= rd_valid_n;
      rise_p     <= {rise_p[0], rise};
      if (rx_clr)         rx <= '0;
      else if (rise_p[1]) rx <= {rx[6:0], miso_s};
    end
  end
endmodule

// File: tb/tb_rf_spi_master.sv
// Scoreboard bench for rf_spi_master: random and directed commands against a frame-level model.
module tb_rf_spi_master;
  import rf_spi_master_pkg::*;

  localparam int CLK_DIV  = 2;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int CS_GAP   = 4;

  typedef struct {
    int          nbits;
    logic [23:0] bits;
    logic        rd;
    logic [7:0]  rbyte;
    int          rlow;
  } exp_t;

  typedef struct {
    int         n;
    logic [7:0] b;
  } slv_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk, mosi, cs_n, intr;
  logic miso = 1'b0;
  logic intr_n = 1'b1;

  rf_spi_master_if bus ();

  rf_spi_master #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .rst(rst), .bus(bus), .sclk(sclk), .mosi(mosi), .miso(miso),
    .cs_n(cs_n), .intr_n(intr_n), .intr(intr)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   frames = 0;
  int   exp_frames = 0;
  exp_t q[$];
  slv_t sq[$];
  logic [7:0] last_rd = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  // Reference: frame bits and ready-low time straight from the command encoding rules.
  function automatic exp_t model(input logic [1:0] i, input logic [9:0] a, input logic [7:0] d,
                                 input logic [7:0] rb);
    exp_t e;
    logic wr;
    logic [7:0] dp;
    wr = i[0];
    dp = wr ? d : 8'h00;
    if (i[1]) begin
      e.nbits = 24;
      e.bits  = (24'(1) << 23) | (24'(a) << 13) | (24'(wr) << 12) | 24'(dp);
    end else begin
      e.nbits = 16;
      e.bits  = (24'(a[5:0]) << 9) | (24'(wr) << 8) | 24'(dp);
    end
    e.rd    = !wr;
    e.rbyte = rb;
    e.rlow  = CS_SETUP + 2 * CLK_DIV * e.nbits + CS_HOLD + CS_GAP;
    return e;
  endfunction

  // Mode-0 transceiver model: bit 0 valid at cs_n fall, next bit after each sclk fall.
  initial begin
    slv_t cur;
    int k;
    logic [23:0] junk;
    forever begin
      @(negedge cs_n);
      cur = '{n: 16, b: 8'h00};
      if (sq.size() > 0) cur = sq.pop_front();
      junk = 24'($urandom);
      k = 0;
      while (cs_n == 1'b0) begin
        #1;
        if (k < cur.n - 8) miso = junk[k];
        else if (k < cur.n) miso = cur.b[7 - (k - (cur.n - 8))];
        else miso = 1'b0;
        @(negedge sclk or posedge cs_n);
        k++;
      end
    end
  end

  // Monitor: collects one frame per ready-low window and scores it on the ready rise.
  int          rl = 0, cl = 0, nb = 0, rv_cnt = 0;
  logic [23:0] obs = '0;
  logic        prev_ready = 1'b1, prev_sclk = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_ready = 1'b1; prev_sclk = 1'b0;
      rl = 0; cl = 0; nb = 0; rv_cnt = 0; obs = '0;
      last_rd = 8'h00;
    end else begin
      if (!bus.ready) rl++;
      if (!cs_n) cl++;
      if (sclk && !prev_sclk) begin
        obs = {obs[22:0], mosi};
        nb++;
      end
      if (bus.rd_valid) begin
        rv_cnt++;
        if (!(bus.ready && !prev_ready)) chk("rd_valid_aligned", 32'(bus.ready && !prev_ready), 32'd1);
      end
      if (bus.ready && !prev_ready) begin
        frames++;
        if (q.size() == 0) chk("unexpected_frame", 32'(q.size()), 32'd1);
        else begin
          e = q.pop_front();
          chk("nbits", nb, e.nbits);
          chk("mosi_stream", 32'(obs), 32'(e.bits));
          chk("ready_low_clks", rl, e.rlow);
          chk("cs_low_clks", cl, e.rlow - CS_GAP);
          if (e.rd) begin
            chk("rd_valid_pulses", rv_cnt, 1);
            chk("rd_data", 32'(bus.rd_data), 32'(e.rbyte));
            last_rd = e.rbyte;
          end else begin
            chk("wr_rd_valid_pulses", rv_cnt, 0);
            chk("wr_rd_data_held", 32'(bus.rd_data), 32'(last_rd));
          end
        end
        rl = 0; cl = 0; nb = 0; rv_cnt = 0; obs = '0;
      end
      prev_ready = bus.ready;
      prev_sclk  = sclk;
    end
  end

  task automatic wait_ready(input int lim);
    int n;
    n = 0;
    while (!bus.ready && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) chk("ready_timeout", 32'(bus.ready), 32'd1);
  endtask

  task automatic issue(input logic [1:0] i, input logic [9:0] a, input logic [7:0] d,
                       input logic [7:0] rb, input bit push);
    @(negedge clk);
    wait_ready(400);
    sq.push_back('{n: (i[1] ? 24 : 16), b: rb});
    if (push) begin
      q.push_back(model(i, a, d, rb));
      exp_frames++;
    end
    bus.inst    = inst_e'(i);
    bus.addr_in = a;
    bus.data_in = d;
    bus.cs_in   = 1'b1;
    @(negedge clk);
    bus.cs_in   = 1'b0;
  endtask

  task automatic wait_done();
    @(negedge clk);
    wait_ready(400);
  endtask

  task automatic intr_test();
    int n;
    @(negedge clk);
    #2 intr_n = 1'b0;
    n = 0;
    while (!intr && n < 6) begin
      @(posedge clk);
      #1 n++;
    end
    chk_range("intr_rise_clks", n, 2, 3);
    repeat (5 - n) @(posedge clk);
    #3 intr_n = 1'b1;
    n = 0;
    while (intr && n < 6) begin
      @(posedge clk);
      #1 n++;
    end
    chk_range("intr_fall_clks", n, 2, 3);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] ri;
    int r, n;
    logic ps;
    bus.cs_in = 1'b0; bus.inst = INST_SHORT_RD; bus.addr_in = '0; bus.data_in = '0;

    #12;
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_cs_n", 32'(cs_n), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_intr", 32'(intr), 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;

    issue(2'b01, 10'h02A, 8'hA5, 8'h00, 1'b1); wait_done();
    issue(2'b00, 10'h031, 8'hFF, 8'h08, 1'b1); wait_done();
    issue(2'b10, 10'h200, 8'h55, 8'h7E, 1'b1); wait_done();

    // Second strobe mid-frame must be dropped.
    issue(2'b11, 10'h3FF, 8'h3C, 8'h00, 1'b1);
    repeat (20) @(negedge clk);
    bus.inst = INST_SHORT_WR; bus.data_in = 8'h99; bus.cs_in = 1'b1;
    @(negedge clk);
    bus.cs_in = 1'b0;
    wait_done();
    repeat (10) @(negedge clk);
    chk("ignored_pulse_idle", 32'(bus.ready), 32'd1);
    chk("ignored_pulse_cs_n", 32'(cs_n), 32'd1);

    // Abort a long read around bit 10 with reset.
    issue(2'b10, 10'h155, 8'h00, 8'hC3, 1'b0);
    r = 0; n = 0; ps = sclk;
    while (r < 10 && n < 400) begin
      @(negedge clk);
      n++;
      if (sclk && !ps) r++;
      ps = sclk;
    end
    chk("abort_reached_bit10", r, 10);
    #2 rst = 1'b1;
    #1;
    chk("abort_cs_n", 32'(cs_n), 32'd1);
    chk("abort_sclk", 32'(sclk), 32'd0);
    chk("abort_ready", 32'(bus.ready), 32'd1);
    chk("abort_rd_valid", 32'(bus.rd_valid), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    issue(2'b00, 10'h017, 8'h00, 8'h5A, 1'b1); wait_done();

    intr_test();
    fork
      begin
        issue(2'b11, 10'($urandom), 8'($urandom), 8'h00, 1'b1);
        wait_done();
      end
      begin
        repeat (30) @(negedge clk);
        intr_test();
      end
    join

    // cs_in held high across ready rise: next command starts one cycle later.
    issue(2'b00, 10'h00C, 8'h00, 8'hB1, 1'b1);
    sq.push_back('{n: 24, b: 8'h4D});
    q.push_back(model(2'b10, 10'h2C1, 8'h00, 8'h4D));
    exp_frames++;
    bus.inst = INST_LONG_RD; bus.addr_in = 10'h2C1; bus.data_in = 8'h00; bus.cs_in = 1'b1;
    wait_ready(400);
    @(negedge clk);
    bus.cs_in = 1'b0;
    chk("held_cs_accept", 32'(bus.ready), 32'd0);
    wait_done();

    for (int t = 0; t < 16; t++) begin
      ri = 2'($urandom_range(0, 3));
      issue(ri, 10'($urandom), 8'($urandom), 8'($urandom), 1'b1);
    end
    wait_done();
    repeat (10) @(negedge clk);

    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    chk("frame_count", frames, exp_frames);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
